pool_controller: RTL and testbench
==================================

# pool_controller

Sequencer that drives the 2x2 max-pooling unit across one full feature map. It reads each 2x2 window from the convolution output buffer, presents the four samples to the pooling unit, and captures the pooled result. It then writes the result to the pooled-map buffer in raster order. It sits between the convolution-layer result RAM and the next layer's input RAM and is started once per feature map by the layer sequencer.

## Interface
- DATA_W, 22, sample width (signed two's complement)
- IMG_W, 128, input map width in samples (even, >= 2)
- IMG_H, 128, input map height in rows (even, >= 2)
- IN_AW, clog2(IMG_W*IMG_H), input buffer address width (derived)
- OUT_AW, clog2(IMG_W*IMG_H/4), output buffer address width (derived)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a map when idle
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the last pooled write
- rd_en  out  1  input buffer read strobe
- rd_addr  out  IN_AW  input buffer address
- rd_data  in  DATA_W  input buffer data, valid exactly 1 cycle after rd_en
- pool_en  out  1  enable to pooling unit
- pool_in1..pool_in4  out  DATA_W each  window samples: top-left, top-right, bottom-left, bottom-right
- pool_out  in  DATA_W  pooled result (signed)
- pool_done  in  1  result valid flag from the pooling unit
- wr_en  out  1  output buffer write strobe
- wr_addr  out  OUT_AW  output buffer address
- wr_data  out  DATA_W  pooled value

## Operation
- States: IDLE, FETCH, LAST, POOL, CAPT, WRITE, DONE.
- IDLE: busy=0. On start=1, clear window row r, column c and output address. Go to FETCH.
- FETCH: 4 cycles, k=0..3. rd_en=1, rd_addr = base + {0, 1, IMG_W, IMG_W+1}[k], with base = r*IMG_W + c. Data returned for k-1 is latched into window register k-1. After k=3, go to LAST.
- LAST: 1 cycle. rd_en=0. Latch the 4th sample. Go to POOL.
- POOL: pool_en=1, pool_in1..4 driven from the window registers, stable through CAPT. Go to CAPT.
- CAPT: pool_en stays 1. When pool_done=1, latch pool_out and go to WRITE. Otherwise wait, with no timeout.
- WRITE: wr_en=1, wr_addr = output counter, wr_data = latched result. Then advance:
  - c += 2;
  - if c reaches IMG_W, set c = 0 and r += 2;
  - output counter += 1.
  - If this was the last window (r = IMG_H-2, c = IMG_W-2), go to DONE. Otherwise go to FETCH.
- DONE: done=1 for 1 cycle, busy=0. Go to IDLE.
- start is ignored in every state except IDLE. start in the DONE cycle is also ignored.
- The controller never alters data. Signed compare and the negative clamp value 22'h200000 belong to the pooling unit.
- Address arithmetic is unsigned. Counters are sized so that no wrap occurs within one map.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, counters=0, window and result registers=0;
  - busy=0, done=0, rd_en=0, rd_addr=0, pool_en=0, pool_in1..4=0, wr_en=0, wr_addr=0, wr_data=0.
- All outputs are registered or decoded from registered state. There is no combinational path from rd_data or pool_out to any output.
- busy rises the cycle after start is sampled.
- Per window: 4 FETCH + 1 LAST + 1 POOL + CAPT(>=1) + 1 WRITE cycles. This is 8 cycles when pool_done follows pool_en by one cycle.
- For the default 128x128 map: 4096 windows x 8 cycles = 32768 cycles, then 1 DONE cycle.
- Reset mid-map aborts immediately. No partial write completes after rst_n falls.

## Structure
- Package pool_pkg:
  - DATA_W;
  - state enum (IDLE..DONE);
  - window offset constants;
  - POOL_MIN = 22'h200000.
- One sub-module, pool_addr_gen: owns r, c and the output counter. Provides rd_addr offset selection, the last-window flag and the advance strobe.
- Top level holds the FSM, window registers and result register.

## Test plan
- IMG_W=4, IMG_H=4, input = 0..15 raster, stub pooling unit responds in 1 cycle:
  - writes [5, 7, 13, 15] to addresses 0..3;
  - done pulses 33 cycles after start.
- All-negative map: window {-5, -1, -9, -3} (22-bit two's complement) -> pool_in1..4 carry those exact values in order; wr_data = -1.
- Stub delays pool_done by 3 cycles -> controller holds CAPT, pool_en stays 1, inputs stay stable, a single write occurs, and the window takes 10 cycles.
- start pulsed again while busy and in the DONE cycle -> ignored; exactly 4 writes per map.
- rst_n low during the second window's FETCH -> all outputs 0 asynchronously; a new start re-runs from address 0 and writes [5, 7, 13, 15].
- Default 128x128 with random data vs. reference model -> 4096 writes, addresses 0..4095 in order, all values match.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 max-pooling sequencer.
package pool_pkg;

  localparam int DATA_W = 22;

  typedef enum logic [2:0] {
    IDLE, FETCH, LAST, POOL, CAPT, WRITE, DONE
  } state_e;

  // Window sample k (0..3 = TL, TR, BL, BR): bit k set means +1 column / +1 row.
  localparam logic [3:0] WIN_DX = 4'b1010;
  localparam logic [3:0] WIN_DY = 4'b1100;

  // Most negative sample; the pooling unit's clamp value.
  localparam logic [DATA_W-1:0] POOL_MIN = 22'h200000;

endpackage

// File: rtl/pool_addr_gen.sv
// Window walker: owns row/column/output counters and the per-window fetch index.
module pool_addr_gen #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int IN_AW  = $clog2(IMG_W*IMG_H),
  parameter int OUT_AW = (IMG_W*IMG_H > 4) ? $clog2(IMG_W*IMG_H/4) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              fetch,
  input  logic              step,
  output logic [1:0]        k,
  output logic [IN_AW-1:0]  rd_addr,
  output logic [OUT_AW-1:0] wr_addr,
  output logic              last_win
);
  import pool_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0]    C_LAST = CW'(IMG_W - 2);
  localparam logic [RW-1:0]    R_LAST = RW'(IMG_H - 2);
  localparam logic [IN_AW-1:0] W_A    = IN_AW'(IMG_W);

  logic [CW-1:0]     c_q, c_d;
  logic [RW-1:0]     r_q, r_d;
  logic [OUT_AW-1:0] o_q, o_d;
  logic [1:0]        k_q, k_d;

  always_comb begin
    c_d = c_q;
    r_d = r_q;
    o_d = o_q;
    k_d = k_q;
    if (clr) begin
      c_d = '0;
      r_d = '0;
      o_d = '0;
      k_d = '0;
    end else begin
      if (fetch) k_d = k_q + 2'd1;
      if (step) begin
        o_d = o_q + OUT_AW'(1);
        if (c_q == C_LAST) begin
          c_d = '0;
          r_d = r_q + RW'(2);
        end else begin
          c_d = c_q + CW'(2);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
      r_q <= '0;
      o_q <= '0;
      k_q <= '0;
    end else begin
      c_q <= c_d;
      r_q <= r_d;
      o_q <= o_d;
      k_q <= k_d;
    end
  end

  assign k        = k_q;
  assign wr_addr  = o_q;
  assign last_win = (r_q == R_LAST) && (c_q == C_LAST);
  assign rd_addr  = IN_AW'(r_q) * W_A + IN_AW'(c_q)
                  + (WIN_DY[k_q] ? W_A : '0) + IN_AW'(WIN_DX[k_q]);

endmodule

// File: rtl/pool_controller.sv
// Sequences 2x2 windows of a feature map through the pooling unit and writes
// pooled results in raster order.
module pool_controller #(
  parameter int DATA_W = pool_pkg::DATA_W,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int IN_AW  = $clog2(IMG_W*IMG_H),
  parameter int OUT_AW = (IMG_W*IMG_H > 4) ? $clog2(IMG_W*IMG_H/4) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [IN_AW-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pool_en,
  output logic [DATA_W-1:0] pool_in1,
  output logic [DATA_W-1:0] pool_in2,
  output logic [DATA_W-1:0] pool_in3,
  output logic [DATA_W-1:0] pool_in4,
  input  logic [DATA_W-1:0] pool_out,
  input  logic              pool_done,
  output logic              wr_en,
  output logic [OUT_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
  import pool_pkg::*;

  state_e                   state_q, state_d;
  logic [3:0][DATA_W-1:0]   win_q, win_d;
  logic [DATA_W-1:0]        res_q, res_d;
  logic                     clr, fetch, step, last_win;
  logic [1:0]               k;

  pool_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .IN_AW (IN_AW),
    .OUT_AW(OUT_AW)
  ) u_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .fetch   (fetch),
    .step    (step),
    .k       (k),
    .rd_addr (rd_addr),
    .wr_addr (wr_addr),
    .last_win(last_win)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    res_d   = res_q;
    clr     = 1'b0;
    fetch   = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        fetch = 1'b1;
        // Read data lags the strobe by one cycle, so sample k-1 lands now.
        if (k != 2'd0) win_d[k - 2'd1] = rd_data;
        if (k == 2'd3) state_d = LAST;
      end
      LAST: begin
        win_d[3] = rd_data;
        state_d  = POOL;
      end
      POOL: state_d = CAPT;
      CAPT: begin
        if (pool_done) begin
          res_d   = pool_out;
          state_d = WRITE;
        end
      end
      WRITE: begin
        step    = 1'b1;
        state_d = last_win ? DONE : FETCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      res_q   <= res_d;
    end
  end

  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);
  assign rd_en    = (state_q == FETCH);
  assign pool_en  = (state_q == POOL) || (state_q == CAPT);
  assign wr_en    = (state_q == WRITE);
  assign pool_in1 = win_q[0];
  assign pool_in2 = win_q[1];
  assign pool_in3 = win_q[2];
  assign pool_in4 = win_q[3];
  assign wr_data  = res_q;

endmodule

// File: tb/tb_pool_controller.sv
// Bench: a 4x4 instance for directed corner cases and a 128x128 instance on
// random data, both checked against a window-max reference model.
module tb_pool_controller;
  import pool_pkg::*;

  localparam int DW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  int total = 0;
  int bad   = 0;

  // ---------------- 4x4 instance ----------------
  logic          s_start, s_busy, s_done, s_rd_en, s_pool_en, s_pool_done, s_wr_en;
  logic [3:0]    s_rd_addr;
  logic [1:0]    s_wr_addr;
  logic [DW-1:0] s_rd_data, s_p1, s_p2, s_p3, s_p4, s_pool_out, s_wr_data;
  logic [DW-1:0] s_mem [16];
  int            s_dly = 1;
  int            s_cnt;
  int            s_unstable = 0;
  int            s_pen = 0;
  logic [4*DW-1:0] s_snap;
  logic [4*DW-1:0] s_pq[$];
  logic [1:0]      s_wa[$];
  logic [DW-1:0]   s_wd[$];
  int ramp_exp[4] = '{5, 7, 13, 15};

  pool_controller #(.IMG_W(4), .IMG_H(4)) u_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .pool_en(s_pool_en), .pool_in1(s_p1), .pool_in2(s_p2), .pool_in3(s_p3), .pool_in4(s_p4),
    .pool_out(s_pool_out), .pool_done(s_pool_done),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data)
  );

  // ---------------- 128x128 instance ----------------
  logic          b_start, b_busy, b_done, b_rd_en, b_pool_en, b_pool_done, b_wr_en;
  logic [13:0]   b_rd_addr;
  logic [11:0]   b_wr_addr;
  logic [DW-1:0] b_rd_data, b_p1, b_p2, b_p3, b_p4, b_pool_out, b_wr_data;
  logic [DW-1:0] b_mem [16384];
  int            b_cnt;
  logic [11:0]   b_wa[$];
  logic [DW-1:0] b_wd[$];

  pool_controller #(.IMG_W(128), .IMG_H(128)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .pool_en(b_pool_en), .pool_in1(b_p1), .pool_in2(b_p2), .pool_in3(b_p3), .pool_in4(b_p4),
    .pool_out(b_pool_out), .pool_done(b_pool_done),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
  );

  // ---------------- stub pooling units and buffers ----------------
  function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
    logic signed [DW-1:0] m;
    m = POOL_MIN;
    if ($signed(a) > m) m = a;
    if ($signed(b) > m) m = b;
    if ($signed(c) > m) m = c;
    if ($signed(d) > m) m = d;
    return m;
  endfunction

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  assign s_pool_out  = max4(s_p1, s_p2, s_p3, s_p4);
  assign s_pool_done = s_pool_en && (s_cnt == s_dly);
  assign b_pool_out  = max4(b_p1, b_p2, b_p3, b_p4);
  assign b_pool_done = b_pool_en && (b_cnt == 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt <= 0;
      b_cnt <= 0;
    end else begin
      s_cnt <= s_pool_en ? s_cnt + 1 : 0;
      b_cnt <= b_pool_en ? b_cnt + 1 : 0;
    end
  end

  always @(posedge clk) begin
    if (s_rd_en) s_rd_data <= s_mem[s_rd_addr];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
    if (s_pool_en) begin
      s_pen <= s_pen + 1;
      if (s_cnt == 0) begin
        s_snap <= {s_p1, s_p2, s_p3, s_p4};
        s_pq.push_back({s_p1, s_p2, s_p3, s_p4});
      end else if ({s_p1, s_p2, s_p3, s_p4} !== s_snap) begin
        s_unstable <= s_unstable + 1;
      end
    end
    if (s_wr_en) begin s_wa.push_back(s_wr_addr); s_wd.push_back(s_wr_data); end
    if (b_wr_en) begin b_wa.push_back(b_wr_addr); b_wd.push_back(b_wr_data); end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Max of the 2x2 window w of the 4x4 map, straight from the image array.
  function automatic int s_model(input int w);
    int r, c, m, v;
    r = (w / 2) * 2;
    c = (w % 2) * 2;
    m = sx(s_mem[r*4 + c]);
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = sx(s_mem[(r+dy)*4 + c + dx]);
        if (v > m) m = v;
      end
    return m;
  endfunction

  function automatic int b_model(input int w);
    int r, c, m, v;
    r = (w / 64) * 2;
    c = (w % 64) * 2;
    m = sx(b_mem[r*128 + c]);
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = sx(b_mem[(r+dy)*128 + c + dx]);
        if (v > m) m = v;
      end
    return m;
  endfunction

  task automatic chk_idle(input string tag);
    check({tag, "_busy"},    s_busy, 0);
    check({tag, "_done"},    s_done, 0);
    check({tag, "_rd_en"},   s_rd_en, 0);
    check({tag, "_rd_addr"}, s_rd_addr, 0);
    check({tag, "_pool_en"}, s_pool_en, 0);
    check({tag, "_pool_in"}, {s_p1, s_p2, s_p3, s_p4}, 0);
    check({tag, "_wr_en"},   s_wr_en, 0);
    check({tag, "_wr_addr"}, s_wr_addr, 0);
    check({tag, "_wr_data"}, s_wr_data, 0);
  endtask

  task automatic chk_writes(input string tag, input int base, input bit ramp);
    int e;
    check({tag, "_nwrites"}, s_wa.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      e = ramp ? ramp_exp[i] : s_model(i);
      check($sformatf("%s_addr%0d", tag, i), s_wa[base+i], i);
      check($sformatf("%s_data%0d", tag, i), sx(s_wd[base+i]), e);
    end
  endtask

  task automatic run_small(input bit extra, output int n);
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    n = 1;
    check("busy_rise", s_busy, 1);
    while (!s_done && n < 300) begin
      if (extra && n == 10) s_start = 1'b1;
      if (extra && n == 11) s_start = 1'b0;
      @(negedge clk); n++;
    end
    check("done_seen", s_done, 1);
    check("busy_in_done", s_busy, 0);
    if (extra) s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    check("done_one_cycle", s_done, 0);
    if (extra) begin
      repeat (3) @(negedge clk);
      check("start_in_done_ignored", s_busy, 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, base, pbase, pen0, na, nd, lim;
    logic [4*DW-1:0] neg_win;
    s_start = 1'b0;
    b_start = 1'b0;
    for (int i = 0; i < 16; i++) s_mem[i] = DW'(i);
    for (int i = 0; i < 16384; i++) b_mem[i] = DW'($urandom);
    #2 rst_n = 1'b0;
    #10;
    chk_idle("reset");
    check("reset_b_busy", b_busy, 0);
    check("reset_b_wr_en", b_wr_en, 0);
    @(negedge clk); rst_n = 1'b1;

    // Ramp image, 1-cycle pooling response
    base = s_wa.size();
    run_small(1'b0, n);
    check("ramp_done_cycles", n, 33);
    chk_writes("ramp", base, 1'b1);

    // All-negative image
    for (int i = 0; i < 16; i++) s_mem[i] = DW'(-int'($urandom_range(1, 1000)));
    s_mem[0] = DW'(-5); s_mem[1] = DW'(-1); s_mem[4] = DW'(-9); s_mem[5] = DW'(-3);
    neg_win = {s_mem[0], s_mem[1], s_mem[4], s_mem[5]};
    base  = s_wa.size();
    pbase = s_pq.size();
    run_small(1'b0, n);
    check("neg_pool_in", s_pq[pbase], neg_win);
    check("neg_wr0", sx(s_wd[base]), -1);
    chk_writes("neg", base, 1'b0);

    // Slow pooling unit: three-cycle response
    for (int i = 0; i < 16; i++) s_mem[i] = DW'(i);
    s_dly = 3;
    pen0 = s_pen;
    base = s_wa.size();
    run_small(1'b0, n);
    check("slow_done_cycles", n, 41);
    check("slow_pool_en_cycles", s_pen - pen0, 16);
    check("slow_inputs_stable", s_unstable, 0);
    chk_writes("slow", base, 1'b1);
    s_dly = 1;

    // Extra start pulses while busy and in the DONE cycle
    base = s_wa.size();
    run_small(1'b1, n);
    check("restart_done_cycles", n, 33);
    chk_writes("restart", base, 1'b1);

    // Reset during the second window's fetch
    base = s_wa.size();
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_fetch", s_rd_en, 1);
    rst_n = 1'b0;
    #1;
    chk_idle("abort");
    check("abort_writes", s_wa.size() - base, 1);
    repeat (2) @(negedge clk);
    check("abort_no_write", s_wa.size() - base, 1);
    rst_n = 1'b1;
    base = s_wa.size();
    run_small(1'b0, n);
    check("rerun_done_cycles", n, 33);
    chk_writes("rerun", base, 1'b1);

    // Full 128x128 map on random data
    base = b_wa.size();
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    n = 1;
    while (!b_done && n < 40000) begin
      @(negedge clk); n++;
    end
    check("big_done_seen", b_done, 1);
    check("big_done_cycles", n, 32769);
    check("big_nwrites", b_wa.size() - base, 4096);
    na = 0;
    nd = 0;
    lim = (b_wa.size() - base < 4096) ? b_wa.size() - base : 4096;
    for (int i = 0; i < lim; i++) begin
      if (int'(b_wa[base+i]) != i) na++;
      if (sx(b_wd[base+i]) != b_model(i)) nd++;
    end
    check("big_first_value", sx(b_wd[base]), b_model(0));
    check("big_addr_mismatches", na, 0);
    check("big_data_mismatches", nd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
